cla8_seq_mul: RTL and testbench



---
 rtl/cla8_pkg.sv | 14 +
 rtl/cla8_seq_mul_cla.sv | 39 +++
 rtl/cla8_seq_mul.sv | 148 ++++++++++++++
 tb/tb_cla8_seq_mul.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cla8_pkg.sv
// Shared types and constants for the CLA-based arithmetic datapath.
package cla8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned MUL_W     = 8;
  localparam int unsigned PROD_W    = 16;
  localparam logic [2:0]  ITER_LAST = 3'd7;

endpackage

// File: rtl/cla8_seq_mul_cla.sv
// 8-bit carry-lookahead adder: every carry is a flat sum of generate/propagate products.
module cla8_seq_mul_cla
  import cla8_pkg::*;
(
  input  logic [MUL_W-1:0] a_i,
  input  logic [MUL_W-1:0] b_i,
  input  logic             cin_i,
  output logic [MUL_W-1:0] sum_o,
  output logic             cout_o
);

  logic [MUL_W-1:0] gen;
  logic [MUL_W-1:0] prop;
  logic [MUL_W:0]   carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded rather than rippled
  always_comb begin
    logic term;
    logic prop_run;
    carry[0] = cin_i;
    for (int i = 0; i < int'(MUL_W); i++) begin
      term     = gen[i];
      prop_run = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        term     = term | (prop_run & gen[j]);
        prop_run = prop_run & prop[j];
      end
      term       = term | (prop_run & cin_i);
      carry[i+1] = term;
    end
  end

  assign sum_o  = prop ^ carry[MUL_W-1:0];
  assign cout_o = carry[MUL_W];

endmodule

// File: rtl/cla8_seq_mul.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around the 8-bit CLA adder.
// Optional build macro CLA8_SEQ_MUL_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero (same result, shorter latency).
module cla8_seq_mul
  import cla8_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          DONE_STICKY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  if (WIDTH != MUL_W) begin : gen_width_check
    $error("cla8_seq_mul: WIDTH must be 8, the CLA adder is fixed at 8 bits");
  end

  state_e              state_q, state_d;
  logic [MUL_W-1:0]    m_q, m_d;
  logic [MUL_W-1:0]    acc_q, acc_d;
  logic [MUL_W-1:0]    mlr_q, mlr_d;
  logic                c_q, c_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                done_q, done_d;

  logic [MUL_W-1:0]    add_b;
  logic [MUL_W-1:0]    add_sum;
  logic                add_cout;
  logic [PROD_W:0]     caq_sum;
  logic [PROD_W:0]     caq_sh;
  logic                finish;
  logic [PROD_W-1:0]   final_prod;

  assign add_b = mlr_q[0] ? m_q : '0;

  cla8_seq_mul_cla u_cla (
    .a_i    (acc_q),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // {C,A,Q} after the add, then the right shift; both land in one register update
  assign caq_sum = {add_cout, add_sum, mlr_q};
  assign caq_sh  = caq_sum >> 1;

`ifdef CLA8_SEQ_MUL_EARLY_EXIT_EN
  logic [3:0]       iter_done;
  logic [MUL_W-1:0] remain_mask;

  // After k iterations the unprocessed multiplier bits sit in Q[7-k:0]
  assign iter_done   = {1'b0, cnt_q} + 4'd1;
  assign remain_mask = 8'hFF >> iter_done;
  assign finish      = ((caq_sh[MUL_W-1:0] & remain_mask) == '0);
  // Skipped iterations would only shift, so apply their shifts all at once
  assign final_prod  = caq_sh[PROD_W-1:0] >> (ITER_LAST - cnt_q);
`else
  assign finish      = (cnt_q == ITER_LAST);
  assign final_prod  = caq_sh[PROD_W-1:0];
`endif

  // Next-state for control and datapath
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    mlr_d     = mlr_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = DONE_STICKY ? done_q : 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          mlr_d   = b;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = caq_sh[PROD_W-1:MUL_W];
        mlr_d = caq_sh[MUL_W-1:0];
        c_d   = caq_sh[PROD_W];
        cnt_d = cnt_q + 3'd1;
        if (finish) begin
          product_d = final_prod;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      mlr_q     <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      mlr_q     <= mlr_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // The carry is always shifted into A, so it must read zero at each iteration
  always_ff @(posedge clk) begin
    if (rst_n && state_q == RUN) begin
      assert (c_q == 1'b0);
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_cla8_seq_mul.sv
// Directed self-checking bench for cla8_seq_mul (fixed and early-exit builds).
module tb_cla8_seq_mul;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a     = '0;
  logic [7:0]  b     = '0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

`ifdef CLA8_SEQ_MUL_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  always #5 clk = ~clk;

  cla8_seq_mul #(
    .WIDTH       (8),
    .DONE_STICKY (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          ee_lat;
  } vec_t;

  vec_t vecs [7] = '{
    '{8'hFF, 8'hFF, 16'hFE01, 8},
    '{8'd13, 8'd11, 16'h008F, 4},
    '{8'h00, 8'hA5, 16'h0000, 8},
    '{8'h80, 8'h02, 16'h0100, 2},
    '{8'd5,  8'd3,  16'h000F, 2},
    '{8'd7,  8'h00, 16'h0000, 1},
    '{8'd3,  8'h80, 16'h0180, 8}
  };

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int ee_lat);
    return EarlyExit ? ee_lat : 8;
  endfunction

  // Present operands with start for one edge; returns #1 after the accept edge
  task automatic launch(input logic [7:0] ma, input logic [7:0] mb, input string tag);
    @(negedge clk);
    a     = ma;
    b     = mb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'hA5;
    b     = 8'h5A;
    check_eq({tag, " busy"}, 32'(busy), 32'd1);
  endtask

  // Count edges until done, then check product and return to IDLE
  task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_p);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " product"}, 32'(product), 32'(exp_p));
    check_eq({tag, " ready_in_done"}, 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, " done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, " ready_after"}, 32'(ready), 32'd1);
    check_eq({tag, " product_held"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    bit any_done;

    // Reset values, then idle with start low
    #12;
    check_eq("rst product", 32'(product), 32'h0);
    check_eq("rst ready", 32'(ready), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("idle product", 32'(product), 32'h0);
    check_eq("idle ready", 32'(ready), 32'd1);
    check_eq("idle busy", 32'(busy), 32'd0);
    check_eq("idle done", 32'(done), 32'd0);

    // Directed operand pairs
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      launch(vecs[i].a, vecs[i].b, tag);
      wait_done(tag, lat_of(vecs[i].ee_lat), vecs[i].p);
    end

    // Start pulsed mid-RUN must be ignored
    launch(8'd3, 8'd5, "ign");
    a     = 8'd9;
    b     = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", lat_of(3) - 1, 16'h000F);
    @(posedge clk);
    #1;
    check_eq("ign no_requeue", 32'(busy), 32'd0);

    // Start held high: second accept on the edge ready returns
    @(negedge clk);
    a     = 8'd6;
    b     = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd10;
    b = 8'd12;
    wait_done("held1", lat_of(3), 16'h002A);
    @(posedge clk);
    #1;
    check_eq("held reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("held2", lat_of(4), 16'h0078);

    // Reset in the 4th RUN cycle aborts and clears product
    launch(8'd200, 8'd200, "abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort product", 32'(product), 32'h0);
    check_eq("abort ready", 32'(ready), 32'd1);
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      any_done = any_done | done;
    end
    check_eq("abort no_done", 32'(any_done), 32'd0);
    launch(8'd200, 8'd200, "post_abort");
    wait_done("post_abort", lat_of(8), 16'h9C40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
